// File: rtl/io_entry_browser.sv
// Switch/button front-end: debounced entry into a DEPTH-word data region, core start, result browsing.
// Optional macro AUTO_INC_EN: advance the pointer automatically after each entry write.
module io_entry_browser #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned SCAN_CYC     = 4,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic              clk_100mhz,
  input  logic              i_rst,
  input  logic              pulse_next_sw,
  input  logic              pulse_prev_sw,
  input  logic              wen_sw,
  input  logic              start_sw,
  input  logic              data_result,
  input  logic [DATA_W-1:0] wdata_sw,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic [0:6]        seg,
  output logic [3:0]        digit,
  output logic              dp
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned SCW = $clog2(SCAN_CYC + 1);
  localparam int unsigned B_NEXT = 0, B_PREV = 1, B_WEN = 2, B_START = 3;

  typedef enum logic [1:0] {ST_ENTRY, ST_RUN, ST_RESULT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       raw, sync1_q, sync2_q, db_q, dbp_q, pulse;
  logic [DBW-1:0]   db_cnt_q [4];
  logic [AW-1:0]    ptr_q, ptr_d, ptr_step;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic             we_q, we_d, start_q, start_d, browse;
  logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       disp_val;
  logic [3:0]       nib, digit_d;
  logic [0:6]       seg_q;
  logic [3:0]       digit_q;
  logic             dp_q, dp_d;

  assign raw   = {start_sw, wen_sw, pulse_prev_sw, pulse_next_sw};
  assign pulse = db_q & ~dbp_q;

  // Synchronise, then accept a new level only after DEBOUNCE_CYC matching samples.
  always_ff @(posedge clk_100mhz) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      dbp_q   <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      dbp_q   <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYC - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (i_rst) state_q <= ST_ENTRY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTRY:  if (pulse[B_START]) state_d = ST_RUN;
      ST_RUN:    if (cpu_done)       state_d = ST_RESULT;
      ST_RESULT: state_d = ST_RESULT;
      default:   state_d = ST_ENTRY;
    endcase
  end

  assign browse   = pulse[B_NEXT] ^ pulse[B_PREV];
  assign ptr_step = pulse[B_NEXT] ? ptr_q + AW'(1) : ptr_q - AW'(1);

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    start_d = start_q;
    case (state_q)
      ST_ENTRY: begin
        if (browse) ptr_d = ptr_step;
`ifdef AUTO_INC_EN
        else if (we_q) ptr_d = ptr_q + AW'(1);
`endif
        if (pulse[B_WEN]) begin
          we_d    = 1'b1;
          wdata_d = wdata_sw;
        end
        if (pulse[B_START]) begin
          start_d = 1'b1;
          // A coincident write keeps its address; the pointer clears once it lands.
          ptr_d   = pulse[B_WEN] ? ptr_q : '0;
        end
      end
      ST_RUN:    if (we_q) ptr_d = '0;
      ST_RESULT: if (browse) ptr_d = ptr_step;
      default:   ptr_d = '0;
    endcase
  end

  // Display: value zero-extended to 8 bits, scanned one digit per SCAN_CYC cycles.
  always_comb begin
    disp_val   = (state_q == ST_ENTRY && !data_result) ? 8'(wdata_sw) : 8'(mem_rdata);
    scan_cnt_d = scan_cnt_q + SCW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCW'(SCAN_CYC - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
    nib     = 4'h0;
    digit_d = 4'b1111;
    case (idx_d)
      2'd0: begin nib = disp_val[3:0]; digit_d = 4'b1110; end
      2'd1: begin nib = disp_val[7:4]; digit_d = 4'b1101; end
      2'd2: begin
        digit_d = 4'b1011;
        case (state_d)
          ST_RUN:    nib = 4'hC;
          ST_RESULT: nib = 4'hD;
          default:   nib = 4'hE;
        endcase
      end
      default: begin nib = 4'(ptr_d); digit_d = 4'b0111; end
    endcase
    dp_d = !(idx_d == 2'd2 && data_result);
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk_100mhz) begin
    if (i_rst) begin
      ptr_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      start_q    <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= 7'b0000001;
      digit_q    <= 4'b1110;
      dp_q       <= 1'b1;
    end else begin
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      start_q    <= start_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= hex7(nib);
      digit_q    <= digit_d;
      dp_q       <= dp_d;
    end
  end

  assign mem_addr  = ptr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign cpu_start = start_q;
  assign seg       = seg_q;
  assign digit     = digit_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_io_entry_browser.sv
// Directed bench for io_entry_browser with a small data-memory stub and a core-side write port.
module tb_io_entry_browser;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [3:0] btn;
  logic       data_result, cpu_done, mem_we, cpu_start, dp;
  logic [7:0] wdata_sw, mem_wdata, mem_rdata;
  logic [2:0] mem_addr;
  logic [0:6] seg;
  logic [3:0] digit;

  logic [7:0] mem [8];
  logic       core_we;
  logic [2:0] core_addr;
  logic [7:0] core_data;
  int         we_cnt = 0;
  logic [2:0] last_addr;
  logic [7:0] last_wdata;

  int checks = 0;
  int errors = 0;

  logic [3:0] pats [4];

  always #5 clk = ~clk;

  io_entry_browser #(.DATA_W(8), .DEPTH(8), .DEBOUNCE_CYC(4), .SCAN_CYC(4)) dut (
    .clk_100mhz(clk), .i_rst(i_rst),
    .pulse_next_sw(btn[0]), .pulse_prev_sw(btn[1]), .wen_sw(btn[2]), .start_sw(btn[3]),
    .data_result(data_result), .wdata_sw(wdata_sw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_done(cpu_done),
    .seg(seg), .digit(digit), .dp(dp)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt        <= we_cnt + 1;
      last_addr     <= mem_addr;
      last_wdata    <= mem_wdata;
    end else if (core_we) begin
      mem[core_addr] <= core_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    btn = m;
    tick(hold);
    btn = 4'b0000;
    tick(10);
  endtask

  task automatic wait_digit(input logic [3:0] pat, input string tag);
    for (int i = 0; i < 20 && digit !== pat; i++) tick(1);
    chk(tag, 32'(digit), 32'(pat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
    i_rst = 1'b1; btn = 4'b0; data_result = 1'b0; wdata_sw = 8'd0; cpu_done = 1'b0;
    core_we = 1'b0; core_addr = 3'd0; core_data = 8'd0;
    tick(3);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu_start", 32'(cpu_start), 32'd0);
    chk("rst_digit", 32'(digit), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b0000001);
    chk("rst_dp", 32'(dp), 32'd1);
    i_rst = 1'b0;

    // Exact latency of a clean press: raw rise to pointer update is 7 edges.
    btn = 4'b0001;
    tick(6);
    chk("lat_edge6", 32'(mem_addr), 32'd0);
    tick(1);
    chk("lat_edge7", 32'(mem_addr), 32'd1);
    tick(3);
    btn = 4'b0000;
    tick(10);
    chk("single_inc", 32'(mem_addr), 32'd1);
    btn = 4'b0001;
    tick(3);
    btn = 4'b0000;
    tick(10);
    chk("glitch", 32'(mem_addr), 32'd1);

    wait_digit(4'b1011, "dig2_entry");
    chk("seg_state_E", 32'(seg), 32'b0110000);

    for (int i = 0; i < 6; i++) press(4'b0001, 5);
    chk("ptr_to7", 32'(mem_addr), 32'd7);
    press(4'b0001, 5);
    chk("wrap_next", 32'(mem_addr), 32'd0);
    press(4'b0010, 5);
    chk("wrap_prev", 32'(mem_addr), 32'd7);
    press(4'b0011, 5);
    chk("next_prev_same", 32'(mem_addr), 32'd7);
    press(4'b0001, 5);
    chk("back_to0", 32'(mem_addr), 32'd0);

    wdata_sw = 8'd56;
    press(4'b0100, 5);
    chk("wr1_count", 32'(we_cnt), 32'd1);
    chk("wr1_addr", 32'(last_addr), 32'd0);
    chk("wr1_data", 32'(last_wdata), 32'd56);
`ifdef AUTO_INC_EN
    chk("wr1_autoinc", 32'(mem_addr), 32'd1);
`else
    chk("wr1_ptr_hold", 32'(mem_addr), 32'd0);
    press(4'b0001, 5);
    chk("wr1_next", 32'(mem_addr), 32'd1);
`endif
    wdata_sw = 8'd10;
    press(4'b0100, 5);
    chk("wr2_count", 32'(we_cnt), 32'd2);
    chk("wr2_addr", 32'(last_addr), 32'd1);
    chk("wr2_data", 32'(last_wdata), 32'd10);
`ifdef AUTO_INC_EN
    chk("wr2_autoinc", 32'(mem_addr), 32'd2);
`else
    chk("wr2_ptr_hold", 32'(mem_addr), 32'd1);
`endif
    wait_digit(4'b1110, "dig0_entry");
    chk("seg_entry_A", 32'(seg), 32'b0001000);

    press(4'b1000, 5);
    chk("run_cpu_start", 32'(cpu_start), 32'd1);
    chk("run_ptr0", 32'(mem_addr), 32'd0);
    wait_digit(4'b1011, "dig2_run");
    chk("seg_state_C", 32'(seg), 32'b0110001);
    press(4'b0100, 5);
    press(4'b0001, 5);
    chk("run_no_write", 32'(we_cnt), 32'd2);
    chk("run_ptr_hold", 32'(mem_addr), 32'd0);

    core_addr = 3'd1; core_data = 8'h2A; core_we = 1'b1;
    tick(1);
    core_we = 1'b0;
    cpu_done = 1'b1;
    tick(1);
    cpu_done = 1'b0;
    press(4'b0001, 5);
    chk("result_ptr1", 32'(mem_addr), 32'd1);
    wait_digit(4'b1110, "dig0_res");
    chk("seg_res_lo_A", 32'(seg), 32'b0001000);
    wait_digit(4'b1101, "dig1_res");
    chk("seg_res_hi_2", 32'(seg), 32'b0010010);
    wait_digit(4'b1011, "dig2_res");
    chk("seg_state_D", 32'(seg), 32'b1000010);
    wait_digit(4'b0111, "dig3_res");
    chk("seg_ptr_1", 32'(seg), 32'b1001111);
    press(4'b1100, 5);
    chk("result_no_write", 32'(we_cnt), 32'd2);
    chk("result_cpu_start", 32'(cpu_start), 32'd1);

    // Scan order and hold time, with the decimal point tied to digit2.
    data_result = 1'b1;
    tick(2);
    for (int i = 0; i < 20 && digit !== 4'b0111; i++) tick(1);
    for (int i = 0; i < 20 && digit === 4'b0111; i++) tick(1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("scan_digit_%0d", i), 32'(digit), 32'(pats[i/4]));
      chk($sformatf("scan_dp_%0d", i), 32'(dp), (i / 4 == 2) ? 32'd0 : 32'd1);
      tick(1);
    end

    for (int i = 0; i < 4; i++) press(4'b0001, 5);
    chk("result_ptr5", 32'(mem_addr), 32'd5);
    i_rst = 1'b1;
    tick(1);
    chk("mid_rst_ptr", 32'(mem_addr), 32'd0);
    chk("mid_rst_cpu_start", 32'(cpu_start), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_digit", 32'(digit), 32'b1110);
    i_rst = 1'b0;
    wait_digit(4'b1011, "dig2_after_rst");
    chk("seg_state_E_again", 32'(seg), 32'b0110000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_entry_browser.md
Name: io_entry_browser

Overview:
- User I/O front-end between board switches/buttons and the RV32I core's data memory.
- Lets a user enter operands into a parametrised DEPTH-word data region, start the core, then browse results with next/prev buttons.
- Drives a 4-digit multiplexed seven-segment display.
- Generalises the fixed single-byte entry path of the current top with debounce, pointer wrap, a mode state machine and readback.

Parameters:
- DATA_W, 8: data width of an entry word (1..8); the display shows the low 8 bits, zero-extended.
- DEPTH, 8: number of addressable entry words (power of 2, 2..16). AW = $clog2(DEPTH).
- DEBOUNCE_CYC, 4: number of consecutive stable cycles needed to accept a button level. Board builds use 1000000.
- SCAN_CYC, 4: cycles each display digit stays active. Board builds use 100000.

Ports:
- clk_100mhz  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- pulse_next_sw  in  1  raw next button, asynchronous
- pulse_prev_sw  in  1  raw prev button, asynchronous
- wen_sw  in  1  raw write button, asynchronous
- start_sw  in  1  raw start button, asynchronous
- data_result  in  1  level: 0 = show switch data, 1 = show memory readback
- wdata_sw  in  DATA_W  entry data switches
- mem_addr  out  AW  data-memory address, equal to the pointer
- mem_wdata  out  DATA_W  write data
- mem_we  out  1  one-cycle write strobe
- mem_rdata  in  DATA_W  combinational read data at mem_addr
- cpu_start  out  1  core run enable, held high
- cpu_done  in  1  core end_of_Instr_WB
- seg  out  [0:6]  segments a..g, active-low
- digit  out  4  digit enables, active-low one-hot
- dp  out  1  decimal point, active-low

Behaviour:
- Button conditioning (all four buttons): 2-flop synchroniser, then debounce counter. The debounced level changes only after DEBOUNCE_CYC identical synchronised samples. A rising edge of the debounced level gives a one-cycle pulse. Latency from a stable raw rise to the pulse is exactly 2+DEBOUNCE_CYC+1 cycles. A glitch shorter than DEBOUNCE_CYC cycles produces no pulse.
- FSM states: ENTRY (reset state), RUN, RESULT.
- ENTRY:
  - next pulse: ptr+1, wrapping DEPTH-1 to 0.
  - prev pulse: ptr-1, wrapping 0 to DEPTH-1.
  - next and prev pulses in the same cycle: ptr unchanged.
  - wen pulse: on the next cycle mem_we=1 for exactly 1 cycle, with mem_addr=ptr and mem_wdata=wdata_sw captured on the pulse cycle.
  - start pulse: go to RUN, set ptr=0 and cpu_start=1. If start and wen pulse in the same cycle, the write completes first and the state changes on the same edge as mem_we.
- RUN: ignores next/prev/wen/start pulses and holds ptr. cpu_done=1 moves to RESULT on the next edge.
- RESULT: next/prev browse with the same wrap rules. wen and start are ignored; mem_we stays 0.
- cpu_start stays 1 from ENTRY exit until i_rst.
- Displayed value: registered each cycle (1-cycle latency).
  - ENTRY with data_result=0: wdata_sw.
  - Otherwise: mem_rdata.
- Display scan:
  - A counter advances the digit index 0,1,2,3,0 every SCAN_CYC cycles.
  - digit0 = value[3:0], digit1 = value[7:4], digit2 = state code (ENTRY 0xE, RUN 0xC, RESULT 0xD), digit3 = ptr zero-extended to 4 bits.
  - seg is a standard hex decode, active-low (0 gives 0000001).
  - dp=0 only while digit2 is active and data_result=1; otherwise dp=1.
- Reset values: state ENTRY, ptr 0, mem_addr 0, mem_we 0, mem_wdata 0, cpu_start 0, debounced levels 0, digit 1110, seg 0000001, dp 1.
- i_rst mid-operation (any state) returns all of the above on the next edge. A pending write strobe is dropped.

Optional Feature:
- Macro: AUTO_INC_EN.
- Defined: in ENTRY, the cycle after each mem_we strobe ptr increments with wrap. If a next/prev pulse coincides with the auto-increment, the button pulse wins and the auto-increment is dropped.
- Undefined: ptr changes only on next/prev pulses.

Test Plan:
- Reset, then raw pulse_next_sw high 10 cycles (DEBOUNCE_CYC=4) -> exactly one ptr increment, 7 cycles after the raw rise, mem_addr=1. A 3-cycle glitch -> no change.
- At ptr=7, next -> ptr 0; at ptr=0, prev -> ptr 7; next and prev pulses in the same cycle -> ptr unchanged.
- wdata_sw=56 at ptr 0, wen -> one mem_we cycle with addr 0, wdata 56. Next, wdata_sw=10, wen -> addr 1, wdata 10. With AUTO_INC_EN: ptr 1 after the first write, no next press needed.
- start -> RUN, cpu_start=1, ptr 0. wen/next during RUN -> no mem_we, ptr 0. cpu_done=1 -> RESULT. Memory word 1 returns 0x2A after next -> digit0 shows A, digit1 shows 2, digit2 shows D.
- Scan check (SCAN_CYC=4): digit sequence 1110,1101,1011,0111 each held 4 cycles. data_result=1 -> dp=0 only during 1011.
- i_rst asserted in RESULT with ptr=5 -> next edge gives ENTRY, ptr 0, cpu_start 0, mem_we 0.
